// File: rtl/result_sram_writer.sv
// Result SRAM writer: streams a rows x cols result matrix from the MAC datapath into SRAM.
// Optional header word {rows, cols} at base_addr when RESULT_WR_HEADER_EN is defined.
module result_sram_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  num_rows,
    input  logic [DIM_WIDTH-1:0]  num_cols,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_ready,
    output logic                  dut__tb__sram_result_write_enable,
    output logic [ADDR_WIDTH-1:0] dut__tb__sram_result_write_address,
    output logic [DATA_WIDTH-1:0] dut__tb__sram_result_write_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CntWidth = 2 * DIM_WIDTH;
`ifdef RESULT_WR_HEADER_EN
    localparam int unsigned HdrOff = 1;
`else
    localparam int unsigned HdrOff = 0;
`endif

    typedef enum logic [1:0] {StIdle, StHdr, StStream, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CntWidth-1:0]   total_q, total_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [CntWidth-1:0]   total_in;
    logic [CntWidth-1:0]   count_inc;

    assign total_in  = CntWidth'(num_rows) * CntWidth'(num_cols);
    assign count_inc = count_q + CntWidth'(1);

`ifdef RESULT_WR_HEADER_EN
    logic [15:0]           hdr_rows;
    logic [15:0]           hdr_cols;
    logic [DATA_WIDTH-1:0] hdr_word;

    assign hdr_rows = 16'(num_rows);
    assign hdr_cols = 16'(num_cols);
    assign hdr_word = DATA_WIDTH'({hdr_rows, hdr_cols});
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        total_d = total_q;
        count_d = count_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    total_d = total_in;
                    count_d = '0;
                    busy_d  = 1'b1;
`ifdef RESULT_WR_HEADER_EN
                    // Header write is registered so it is visible during the HDR cycle.
                    state_d = StHdr;
                    we_d    = 1'b1;
                    addr_d  = base_addr;
                    data_d  = hdr_word;
`else
                    if (total_in == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StStream;
                        ready_d = 1'b1;
                    end
`endif
                end
            end

            StHdr: begin
                if (total_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StStream;
                    ready_d = 1'b1;
                end
            end

            StStream: begin
                if (res_valid && ready_q) begin
                    we_d    = 1'b1;
                    addr_d  = base_q + ADDR_WIDTH'(HdrOff) + ADDR_WIDTH'(count_q);
                    data_d  = res_data;
                    count_d = count_inc;
                    if (count_inc == total_q) begin
                        state_d = StDone;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            total_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            total_q <= total_d;
            count_q <= count_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign res_ready                          = ready_q;
    assign busy                               = busy_q;
    assign done                               = done_q;
    assign dut__tb__sram_result_write_enable  = we_q;
    assign dut__tb__sram_result_write_address = addr_q;
    assign dut__tb__sram_result_write_data    = data_q;

endmodule

// File: tb/tb_result_sram_writer.sv
// Self-checking bench for result_sram_writer: directed and random jobs against a write-list model.
// Follows RESULT_WR_HEADER_EN the same way as the design.
module tb_result_sram_writer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned NW = 16;
`ifdef RESULT_WR_HEADER_EN
    localparam int unsigned HdrEn = 1;
`else
    localparam int unsigned HdrEn = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [NW-1:0] num_rows;
    logic [NW-1:0] num_cols;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    result_sram_writer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DIM_WIDTH (NW)
    ) dut (
        .clk                               (clk),
        .reset_n                           (reset_n),
        .start                             (start),
        .base_addr                         (base_addr),
        .num_rows                          (num_rows),
        .num_cols                          (num_cols),
        .res_valid                         (res_valid),
        .res_data                          (res_data),
        .res_ready                         (res_ready),
        .dut__tb__sram_result_write_enable (we),
        .dut__tb__sram_result_write_address(waddr),
        .dut__tb__sram_result_write_data   (wdata),
        .busy                              (busy),
        .done                              (done)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    logic [DW-1:0] acc[$];
    int            done_cnt;
    int            done_cyc;
    int            cyc;
    logic          busy_s;
    logic          ready_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        acc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Samples everything mid-cycle, then returns just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        busy_s  = busy;
        ready_s = res_ready;
        if (we === 1'b1) begin
            wr_addr.push_back(waddr);
            wr_data.push_back(wdata);
        end
        if (res_ready === 1'b1 && res_valid === 1'b1) acc.push_back(res_data);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    // Expected writes: optional header, then every accepted word in order from base+hdr.
    task automatic verify(input string tag, input logic [AW-1:0] base, input logic [NW-1:0] rows,
                          input logic [NW-1:0] cols);
        logic [AW-1:0] exp_a[$];
        logic [DW-1:0] exp_d[$];
        int            total;
        int            n;
        total = int'(rows) * int'(cols);
        if (HdrEn != 0) begin
            exp_a.push_back(base);
            exp_d.push_back({rows, cols});
        end
        for (int i = 0; i < acc.size(); i++) begin
            exp_a.push_back(AW'(int'(base) + int'(HdrEn) + i));
            exp_d.push_back(acc[i]);
        end
        check({tag, " accepted"}, 64'(acc.size()), 64'(total));
        check({tag, " nwrites"}, 64'(wr_addr.size()), 64'(exp_a.size()));
        n = (wr_addr.size() < exp_a.size()) ? wr_addr.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr[i]), 64'(exp_a[i]));
            check($sformatf("%s data[%0d]", tag, i), 64'(wr_data[i]), 64'(exp_d[i]));
        end
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        if (total == 0) check({tag, " done_latency_ok"}, 64'(done_cyc >= 0 && done_cyc <= 2), 64'd1);
    endtask

    // vmode: 0 valid held high, 1 random valid, 2 valid 1,0,0,1 with a stray start mid-stream.
    task automatic run_job(input string tag, input logic [AW-1:0] base, input logic [NW-1:0] rows,
                           input logic [NW-1:0] cols, input int vmode);
        int limit;
        clear_log();
        limit     = int'(rows) * int'(cols) * 8 + 20;
        cyc       = -1;
        start     = 1'b1;
        base_addr = base;
        num_rows  = rows;
        num_cols  = cols;
        res_valid = 1'b0;
        tick();
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_rows  = NW'($urandom);
        num_cols  = NW'($urandom);
        cyc       = 0;
        while (done_cnt == 0 && cyc < limit) begin
            case (vmode)
                0:       res_valid = 1'b1;
                1:       res_valid = 1'($urandom_range(0, 1));
                default: res_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            res_data = $urandom;
            if (vmode == 2 && cyc == 4) begin
                start     = 1'b1;
                base_addr = 16'h1234;
                num_rows  = 16'd7;
                num_cols  = 16'd7;
            end
            tick();
            if (cyc == 0) check({tag, " busy_after_start"}, 64'(busy_s), 64'd1);
            start = 1'b0;
            cyc++;
        end
        res_valid = 1'b1;
        tick();
        check({tag, " busy_after_done"}, 64'(busy_s), 64'd0);
        check({tag, " ready_after_done"}, 64'(ready_s), 64'd0);
        repeat (3) tick();
        res_valid = 1'b0;
        verify(tag, base, rows, cols);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        num_cols  = '0;
        res_valid = 1'b0;
        res_data  = '0;
        cyc       = 0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst ready", 64'(res_ready), 64'd0);
        check("rst we", 64'(we), 64'd0);
        check("rst addr", 64'(waddr), 64'd0);
        check("rst data", 64'(wdata), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        run_job("basic2x3", 16'h0010, 16'd2, 16'd3, 0);
        run_job("zero_cols", 16'h0040, 16'd3, 16'd0, 0);
        run_job("wrap", 16'hFFFE, 16'd1, 16'd4, 0);
        run_job("gaps_restart", 16'h0100, 16'd2, 16'd3, 2);

        // Reset after two accepted words of a 2x3 job.
        clear_log();
        cyc       = -1;
        start     = 1'b1;
        base_addr = 16'h0300;
        num_rows  = 16'd2;
        num_cols  = 16'd3;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (acc.size() < 2 && cyc < 20) begin
            res_valid = 1'b1;
            res_data  = $urandom;
            tick();
            cyc++;
        end
        check("midrst accepted", 64'(acc.size()), 64'd2);
        res_valid = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst writes_before", 64'(wr_addr.size()), 64'(2 + HdrEn));
        clear_log();
        @(negedge clk);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst ready", 64'(res_ready), 64'd0);
        check("midrst we", 64'(we), 64'd0);
        check("midrst addr", 64'(waddr), 64'd0);
        check("midrst data", 64'(wdata), 64'd0);
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        repeat (5) tick();
        res_valid = 1'b0;
        check("midrst no_writes", 64'(wr_addr.size()), 64'd0);
        check("midrst no_accepts", 64'(acc.size()), 64'd0);
        run_job("after_rst", 16'h0200, 16'd2, 16'd2, 0);

        for (int j = 0; j < 6; j++) begin
            run_job($sformatf("rand%0d", j), AW'($urandom), NW'($urandom_range(0, 4)),
                    NW'($urandom_range(0, 4)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_sram_writer.md
RESULT_SRAM_WRITER -- requirements
Module: result_sram_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, result word and SRAM data width.
REQ-002 Parameter ADDR_WIDTH, default 16, result SRAM address width.
REQ-003 Parameter DIM_WIDTH, default 16, width of the row and column counts.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a matrix write-back.
REQ-007 base_addr  input  ADDR_WIDTH  first result SRAM address, sampled with start.
REQ-008 num_rows  input  DIM_WIDTH  result matrix rows, sampled with start.
REQ-009 num_cols  input  DIM_WIDTH  result matrix columns, sampled with start.
REQ-010 res_valid  input  1  result word available from the MAC datapath.
REQ-011 res_data  input  DATA_WIDTH  FP32 result word.
REQ-012 res_ready  output  1  block accepts res_data this cycle.
REQ-013 dut__tb__sram_result_write_enable  output  1  result SRAM write strobe.
REQ-014 dut__tb__sram_result_write_address  output  ADDR_WIDTH  result SRAM write address.
REQ-015 dut__tb__sram_result_write_data  output  DATA_WIDTH  result SRAM write data.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse after the last write is issued.

Function
REQ-018 The FSM SHALL have the states IDLE, HDR, STREAM and DONE.
- IDLE: start=1 latches base_addr, num_rows, num_cols and total = num_rows*num_cols (2*DIM_WIDTH bits, unsigned).
- IDLE next state: HDR when RESULT_WR_HEADER_EN is defined, otherwise STREAM.
REQ-019 start in any state other than IDLE SHALL be ignored with no effect on the latched values.
REQ-020 HDR SHALL last one cycle and then move to STREAM, or to DONE when total==0.
REQ-021 STREAM: res_ready SHALL be 1; res_ready SHALL be 0 in all other states.
REQ-022 Each handshake (res_valid & res_ready) SHALL produce, in the next cycle:
- write_enable=1;
- write_data = accepted res_data;
- write_address = base + hdr_off + count, where hdr_off is 1 with the header feature and 0 without it, and count is the number of words previously accepted.
REQ-023 Write order SHALL be row-major and sequential, with exactly one SRAM write per accepted word.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_WIDTH, wrapping from all-ones to 0 without error.
REQ-025 When the total-th word is accepted, the FSM SHALL move to DONE in the same edge and deassert res_ready.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE, with busy=0 in that IDLE cycle.
REQ-027 With total==0 the FSM SHALL skip STREAM, accept no words and produce no data writes.
REQ-028 A res_valid gap SHALL stall the count with no write; a write SHALL occur only on the cycle after a handshake.
REQ-029 write_enable SHALL be 0 in every cycle not required by REQ-022 or REQ-031.

Reset
REQ-030 With reset_n=0 at a clock edge, the block SHALL enter IDLE and drive:
- busy=0, done=0, res_ready=0;
- write_enable=0, write_address=0, write_data=0;
- count=0.
An in-flight operation SHALL be abandoned with no further writes, and the pending registered write SHALL be cancelled.

Configuration
REQ-031 Macro RESULT_WR_HEADER_EN, when defined:
- in the HDR cycle the block SHALL write {num_rows[15:0], num_cols[15:0]} to base_addr;
- data SHALL start at base_addr+1.
When the macro is undefined, the HDR state is unreachable, no header is written, and data starts at base_addr.

Verification
REQ-032 Header on, start with base=0x0010, rows=2, cols=3, six words with res_valid held 1:
- header 0x00020003 written at 0x0010;
- data written at 0x0011..0x0016 in order;
- done pulses once;
- busy=0 on the following cycle.
REQ-033 Header off, same stimulus -> data written at 0x0010..0x0015, with no write at any other address.
REQ-034 rows=3, cols=0 -> no data writes (header 0x00030000 only, if enabled), done pulses within 3 cycles of start.
REQ-035 base=0xFFFE, header off, rows=1, cols=4 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-036 res_valid toggling 1,0,0,1 with a second start mid-stream:
- exactly one write per handshake;
- the second start is ignored.
REQ-037 reset_n low for one cycle after 2 of 6 words:
- no writes from the cycle after reset;
- IDLE with outputs at reset values;
- a new start then runs normally.
